// File: rtl/five_scan_ctrl.sv
// Five-in-a-row scan sequencer: walks the 9-cell window through the last stone in 4 directions.
// Optional FIVE_SCAN_FULL_SCAN_EN: scan every direction and report a per-direction win_mask.

module five_checker (
    input  logic [8:0] my,
    output logic       ret,
    output logic [3:0] coord
);

    // Lowest five-run wins; coord is the index of the run's centre cell (2..6).
    always_comb begin
        ret   = 1'b0;
        coord = 4'd0;
        for (int s = 0; s < 5; s++) begin
            if (!ret && (my[s +: 5] == 5'b11111)) begin
                ret   = 1'b1;
                coord = 4'(s + 2);
            end
        end
    end

endmodule

module five_scan_ctrl #(
    parameter int BOARD_SIZE = 15,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        row,
    input  logic [3:0]        col,
    input  logic [1:0]        player,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic              win,
    output logic [1:0]        win_dir,
    output logic [3:0]        win_coord
`ifdef FIVE_SCAN_FULL_SCAN_EN
    ,
    output logic [3:0]        win_mask
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EVAL,
        S_DONE
    } state_t;

    localparam logic signed [6:0] BS = 7'(BOARD_SIZE);

    state_t            state;
    state_t            next_state;
    logic [3:0]        scan_row;
    logic [3:0]        scan_col;
    logic [1:0]        scan_player;
    logic [1:0]        d;
    logic [3:0]        k;
    logic [8:0]        my;
    logic              tag_live;
    logic              tag_valid;
    logic [3:0]        tag_k;
    logic              out_of_range;
    logic signed [6:0] offset;
    logic signed [6:0] r_pos;
    logic signed [6:0] c_pos;
    logic              in_bounds;
    logic [ADDR_W-1:0] cell_addr;
    logic              hit;
    logic [3:0]        hit_coord;
    logic              last_eval;

    five_checker u_checker (
        .my    (my),
        .ret   (hit),
        .coord (hit_coord)
    );

    assign out_of_range = (32'(row) >= BOARD_SIZE) || (32'(col) >= BOARD_SIZE);

    // Window cell k sits at offset k-4 from the placed stone along direction d.
    assign offset = $signed({3'b000, k}) - 7'sd4;
    assign r_pos  = $signed({3'b000, scan_row}) + ((d != 2'd0) ? offset : 7'sd0);

    always_comb begin
        c_pos = $signed({3'b000, scan_col});
        case (d)
            2'd0, 2'd2: c_pos = $signed({3'b000, scan_col}) + offset;
            2'd3:       c_pos = $signed({3'b000, scan_col}) - offset;
            default:    c_pos = $signed({3'b000, scan_col});
        endcase
    end

    assign in_bounds = (r_pos >= 7'sd0) && (r_pos < BS) && (c_pos >= 7'sd0) && (c_pos < BS);
    assign cell_addr = ADDR_W'(r_pos) * ADDR_W'(BOARD_SIZE) + ADDR_W'(c_pos);

`ifdef FIVE_SCAN_FULL_SCAN_EN
    assign last_eval = (d == 2'd3);
`else
    assign last_eval = hit || (d == 2'd3);
`endif

    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        rd_addr    = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                // Bad coordinates go through one empty EVAL so done lands two cycles after start.
                if (start) begin
                    next_state = out_of_range ? S_EVAL : S_READ;
                end
            end
            S_READ: begin
                busy    = 1'b1;
                rd_en   = in_bounds;
                rd_addr = in_bounds ? cell_addr : '0;
                if (k == 4'd8) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                busy       = 1'b1;
                next_state = S_EVAL;
            end
            S_EVAL: begin
                busy       = 1'b1;
                next_state = last_eval ? S_DONE : S_READ;
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            scan_row    <= '0;
            scan_col    <= '0;
            scan_player <= '0;
            d           <= '0;
            k           <= '0;
            my          <= '0;
            tag_live    <= 1'b0;
            tag_valid   <= 1'b0;
            tag_k       <= '0;
            win         <= 1'b0;
            win_dir     <= '0;
            win_coord   <= '0;
`ifdef FIVE_SCAN_FULL_SCAN_EN
            win_mask    <= '0;
`endif
        end else begin
            state     <= next_state;
            tag_live  <= (state == S_READ);
            tag_valid <= (state == S_READ) && in_bounds;
            tag_k     <= k;
            // RAM data returns one cycle after issue; skipped cells land as 0.
            if (tag_live) begin
                my[tag_k] <= tag_valid && (rd_data == scan_player);
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        scan_row    <= row;
                        scan_col    <= col;
                        scan_player <= player;
                        d           <= out_of_range ? 2'd3 : 2'd0;
                        k           <= '0;
                        my          <= '0;
                        win         <= 1'b0;
                        win_dir     <= '0;
                        win_coord   <= '0;
`ifdef FIVE_SCAN_FULL_SCAN_EN
                        win_mask    <= '0;
`endif
                    end
                end
                S_READ: begin
                    k <= k + 4'd1;
                end
                S_EVAL: begin
`ifdef FIVE_SCAN_FULL_SCAN_EN
                    if (hit) begin
                        win_mask[d] <= 1'b1;
                        if (win_mask == 4'd0) begin
                            win_dir   <= d;
                            win_coord <= hit_coord;
                        end
                    end
                    if (d == 2'd3) begin
                        win <= (|win_mask) || hit;
                    end else begin
                        d  <= d + 2'd1;
                        k  <= '0;
                        my <= '0;
                    end
`else
                    if (hit) begin
                        win       <= 1'b1;
                        win_dir   <= d;
                        win_coord <= hit_coord;
                    end else if (d != 2'd3) begin
                        d  <= d + 2'd1;
                        k  <= '0;
                        my <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_five_scan_ctrl.sv
// Directed bench for five_scan_ctrl with a behavioural board RAM; follows FIVE_SCAN_FULL_SCAN_EN.

module tb_five_scan_ctrl;

`ifdef FIVE_SCAN_FULL_SCAN_EN
    localparam bit FULL = 1'b1;
`else
    localparam bit FULL = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] row;
    logic [3:0] col;
    logic [1:0] player;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [1:0] rd_data;
    logic       busy;
    logic       done;
    logic       win;
    logic [1:0] win_dir;
    logic [3:0] win_coord;
`ifdef FIVE_SCAN_FULL_SCAN_EN
    logic [3:0] win_mask;
`endif

    logic [1:0] board [0:255];
    logic       rd_hist [0:63];
    int         tests_run;
    int         fail_count;
    int         done_cyc;
    int         reads;
    int         dones;
    int         busy_bad;

    five_scan_ctrl #(.BOARD_SIZE(15), .ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row       (row),
        .col       (col),
        .player    (player),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .win       (win),
        .win_dir   (win_dir),
        .win_coord (win_coord)
`ifdef FIVE_SCAN_FULL_SCAN_EN
        ,
        .win_mask  (win_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board RAM with one cycle of read latency.
    always @(posedge clk) begin
        rd_data <= rd_en ? board[rd_addr] : 2'b00;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 256; i++) board[i] = 2'b00;
    endtask

    task automatic place(input int r, input int c, input logic [1:0] v);
        board[r * 15 + c] = v;
    endtask

    // Issues one start and watches 60 cycles; optional second start at cycle restart_at.
    task automatic apply_stimulus(input logic [3:0] r, input logic [3:0] c, input logic [1:0] p,
                                  input int restart_at);
        @(negedge clk);
        row = r; col = c; player = p; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cyc = -1; reads = 0; dones = 0; busy_bad = 0;
        for (int i = 0; i < 64; i++) rd_hist[i] = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            rd_hist[cyc] = rd_en;
            if (rd_en === 1'b1) reads++;
            if (done === 1'b1) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (busy !== (done_cyc < 0)) busy_bad++;
            if (cyc == restart_at) begin
                start = 1'b1; row = 4'd15;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        tests_run = 0; fail_count = 0;
        rst = 1'b1; start = 1'b0; row = '0; col = '0; player = '0;
        clear_board();
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_rd_en", rd_en, 0);
        check_output("reset_win", win, 0);
        @(negedge clk); rst = 1'b0;

        // Empty board, centre probe.
        apply_stimulus(4'd7, 4'd7, 2'b01, 0);
        check_output("empty_done_cycle", done_cyc, 45);
        check_output("empty_reads", reads, 36);
        check_output("empty_busy", busy_bad, 0);
        check_output("empty_win", win, 0);
        check_output("empty_dir", win_dir, 0);
        check_output("empty_coord", win_coord, 0);

        // Horizontal black five ending at the probe.
        for (int c = 3; c <= 7; c++) place(7, c, 2'b01);
        apply_stimulus(4'd7, 4'd7, 2'b01, 0);
        check_output("horiz_done_cycle", done_cyc, FULL ? 45 : 12);
        check_output("horiz_reads", reads, FULL ? 36 : 9);
        check_output("horiz_busy", busy_bad, 0);
        check_output("horiz_win", win, 1);
        check_output("horiz_dir", win_dir, 0);
        check_output("horiz_coord", win_coord, 2);
`ifdef FIVE_SCAN_FULL_SCAN_EN
        check_output("horiz_mask", win_mask, 4'b0001);
`endif

        // Corner diagonal: first four window cells fall off the board.
        clear_board();
        for (int i = 0; i <= 4; i++) place(i, i, 2'b01);
        apply_stimulus(4'd0, 4'd0, 2'b01, 0);
        check_output("diag_done_cycle", done_cyc, FULL ? 45 : 34);
        check_output("diag_reads", reads, FULL ? 16 : 15);
        check_output("diag_rd_k0_d0", rd_hist[1], 0);
        check_output("diag_rd_k3_d0", rd_hist[4], 0);
        check_output("diag_rd_k4_d0", rd_hist[5], 1);
        check_output("diag_rd_k0_d2", rd_hist[23], 0);
        check_output("diag_rd_k3_d2", rd_hist[26], 0);
        check_output("diag_rd_k4_d2", rd_hist[27], 1);
        check_output("diag_win", win, 1);
        check_output("diag_dir", win_dir, 2);
        check_output("diag_coord", win_coord, 6);
`ifdef FIVE_SCAN_FULL_SCAN_EN
        check_output("diag_mask", win_mask, 4'b0100);
`endif

        // Vertical white five: black probe must not win, white probe must.
        clear_board();
        for (int r = 3; r <= 7; r++) place(r, 7, 2'b10);
        apply_stimulus(4'd7, 4'd7, 2'b01, 0);
        check_output("vert_black_done", done_cyc, 45);
        check_output("vert_black_win", win, 0);
        apply_stimulus(4'd7, 4'd7, 2'b10, 0);
        check_output("vert_white_done", done_cyc, FULL ? 45 : 23);
        check_output("vert_white_reads", reads, FULL ? 36 : 18);
        check_output("vert_white_win", win, 1);
        check_output("vert_white_dir", win_dir, 1);
        check_output("vert_white_coord", win_coord, 2);
`ifdef FIVE_SCAN_FULL_SCAN_EN
        check_output("vert_white_mask", win_mask, 4'b0010);
`endif

        // Reset in the middle of a scan.
        clear_board();
        @(negedge clk);
        row = 4'd7; col = 4'd7; player = 2'b01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        check_output("mid_rd_en", rd_en, 1);
        check_output("mid_rd_addr", rd_addr, 172);
        rst = 1'b1; #1;
        check_output("rst_busy", busy, 0);
        check_output("rst_rd_en", rd_en, 0);
        check_output("rst_rd_addr", rd_addr, 0);
        check_output("rst_done", done, 0);
        dones = 0;
        repeat (3) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
        @(negedge clk); rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
        check_output("rst_no_done", dones, 0);
        for (int c = 3; c <= 7; c++) place(7, c, 2'b01);
        apply_stimulus(4'd7, 4'd7, 2'b01, 0);
        check_output("post_rst_done", done_cyc, FULL ? 45 : 12);
        check_output("post_rst_win", win, 1);

        // Out-of-range start.
        apply_stimulus(4'd15, 4'd3, 2'b01, 0);
        check_output("oor_done_cycle", done_cyc, 2);
        check_output("oor_reads", reads, 0);
        check_output("oor_win", win, 0);
        check_output("oor_busy", busy_bad, 0);

        // Second start while busy is dropped.
        apply_stimulus(4'd7, 4'd7, 2'b01, 5);
        check_output("dbl_dones", dones, 1);
        check_output("dbl_done_cycle", done_cyc, FULL ? 45 : 12);
        check_output("dbl_win", win, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
